// File: rtl/regfile_wr_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wr_arbiter
// Round-robin arbiter that shares the single write port of the SIMD register
// file between NREQ write-back sources. One valid/ready request is accepted per
// cycle. The accepted write is presented to the register file one cycle later
// on registered rd_wr_en/rd/wr_data.
//
// Parameters
//   NREQ  number of requesters (2..8)
//   AW    register address width
//   DW    write data width
//
// Ports
//   clk           in   clock, posedge active
//   rst_n         in   asynchronous active-low reset
//   arb_en        in   1 = arbitrate, 0 = freeze (no grants)
//   req_valid     in   [NREQ]     per-requester write request
//   req_rd        in   [NREQ*AW]  dest address, requester i at [i*AW +: AW]
//   req_data      in   [NREQ*DW]  write data, requester i at [i*DW +: DW]
//   req_ready     out  [NREQ]     one-hot grant (combinational)
//   rd_wr_en      out  register file write enable (registered)
//   rd            out  [AW]       register file write address (registered)
//   wr_data       out  [DW]       register file write data (registered)
//   grant_id      out  [3]        index of the last accepted requester (registered)
//   conflict_cnt  out  [16]       only when REGFILE_WR_ARB_STATS_EN is defined:
//                                 saturating count of enabled cycles with >=2 requests
//
// Build option: REGFILE_WR_ARB_STATS_EN
// -----------------------------------------------------------------------------
module regfile_wr_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned AW   = 5,
    parameter int unsigned DW   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 arb_en,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*AW-1:0]   req_rd,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rd_wr_en,
    output logic [AW-1:0]        rd,
    output logic [DW-1:0]        wr_data,
`ifdef REGFILE_WR_ARB_STATS_EN
    output logic [2:0]           grant_id,
    output logic [15:0]          conflict_cnt
`else
    output logic [2:0]           grant_id
`endif
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned GW = 3;

    logic [PW-1:0]   r_ptr;
    logic [PW-1:0]   w_ptr_nxt;
    logic [PW-1:0]   w_gnt_idx;
    logic            w_found;
    logic [NREQ-1:0] w_grant;
    logic [AW-1:0]   w_sel_rd;
    logic [DW-1:0]   w_sel_data;

    logic            r_wr_en;
    logic [AW-1:0]   r_rd;
    logic [DW-1:0]   r_wr_data;
    logic [GW-1:0]   r_grant_id;
    logic            w_wr_en_nxt;
    logic [AW-1:0]   w_rd_nxt;
    logic [DW-1:0]   w_wr_data_nxt;
    logic [GW-1:0]   w_grant_id_nxt;

    // Rotating priority search: first valid requester at ptr, ptr+1, ... wrapping.
    always_comb begin : p_search
        logic [PW-1:0] idx;
        w_found   = 1'b0;
        w_gnt_idx = '0;
        idx       = '0;
        if (arb_en) begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                idx = PW'((32'(r_ptr) + k) % NREQ);
                if (!w_found && req_valid[idx]) begin
                    w_found   = 1'b1;
                    w_gnt_idx = idx;
                end
            end
        end
    end

    assign w_grant = w_found ? (NREQ'(1) << w_gnt_idx) : '0;

    // Grants are suppressed while reset is asserted so nothing is lost.
    assign req_ready = rst_n ? w_grant : '0;

    // Payload mux for the granted requester.
    always_comb begin : p_sel
        w_sel_rd   = '0;
        w_sel_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (w_gnt_idx == PW'(i)) begin
                w_sel_rd   = req_rd[i*AW +: AW];
                w_sel_data = req_data[i*DW +: DW];
            end
        end
    end

    // Next pointer and write-port values; r0 writes are accepted but not enabled.
    always_comb begin : p_next
        w_ptr_nxt      = r_ptr;
        w_wr_en_nxt    = 1'b0;
        w_rd_nxt       = r_rd;
        w_wr_data_nxt  = r_wr_data;
        w_grant_id_nxt = r_grant_id;
        if (w_found) begin
            w_ptr_nxt      = (32'(w_gnt_idx) == NREQ - 1) ? '0 : w_gnt_idx + PW'(1);
            w_wr_en_nxt    = (w_sel_rd != '0);
            w_rd_nxt       = w_sel_rd;
            w_wr_data_nxt  = w_sel_data;
            w_grant_id_nxt = GW'(w_gnt_idx);
        end
    end

    // Pointer and registered write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr      <= '0;
            r_wr_en    <= 1'b0;
            r_rd       <= '0;
            r_wr_data  <= '0;
            r_grant_id <= '0;
        end else begin
            r_ptr      <= w_ptr_nxt;
            r_wr_en    <= w_wr_en_nxt;
            r_rd       <= w_rd_nxt;
            r_wr_data  <= w_wr_data_nxt;
            r_grant_id <= w_grant_id_nxt;
        end
    end

    assign rd_wr_en = r_wr_en;
    assign rd       = r_rd;
    assign wr_data  = r_wr_data;
    assign grant_id = r_grant_id;

`ifdef REGFILE_WR_ARB_STATS_EN
    logic [15:0] r_conflict_cnt;
    logic        w_multi;

    // Contention: arbitration enabled with two or more requesters waiting.
    always_comb begin : p_multi
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            n = n + 32'(req_valid[i]);
        end
        w_multi = arb_en && (n >= 2);
    end

    // Saturating contention counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_conflict_cnt <= '0;
        end else if (w_multi && (r_conflict_cnt != 16'hFFFF)) begin
            r_conflict_cnt <= r_conflict_cnt + 16'd1;
        end
    end

    assign conflict_cnt = r_conflict_cnt;
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_wr_arbiter
// Directed bench for regfile_wr_arbiter (NREQ=4, AW=5, DW=16). Each cycle the
// expected grant is checked combinationally; the expected register-file write
// is pushed to a scoreboard queue and popped after the next rising edge.
// -----------------------------------------------------------------------------
module tb_regfile_wr_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned AW   = 5;
    localparam int unsigned DW   = 16;

    typedef struct packed {
        logic          en;
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
        logic [2:0]    gid;
    } exp_t;

    logic               clk;
    logic               rst_n;
    logic               arb_en;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_rd;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               rd_wr_en;
    logic [AW-1:0]      rd;
    logic [DW-1:0]      wr_data;
    logic [2:0]         grant_id;
`ifdef REGFILE_WR_ARB_STATS_EN
    logic [15:0]        conflict_cnt;
`endif

    logic [AW-1:0] tb_rd   [NREQ];
    logic [DW-1:0] tb_data [NREQ];
    exp_t          sb[$];
    exp_t          hold;
    int            total;
    int            bad;

    regfile_wr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .arb_en       (arb_en),
        .req_valid    (req_valid),
        .req_rd       (req_rd),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .rd_wr_en     (rd_wr_en),
        .rd           (rd),
        .wr_data      (wr_data),
`ifdef REGFILE_WR_ARB_STATS_EN
        .grant_id     (grant_id),
        .conflict_cnt (conflict_cnt)
`else
        .grant_id     (grant_id)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        tb_rd[i]   = a;
        tb_data[i] = d;
        for (int j = 0; j < NREQ; j++) begin
            req_rd[j*AW +: AW]   = tb_rd[j];
            req_data[j*DW +: DW] = tb_data[j];
        end
    endtask

    task automatic clear_hold();
        hold = '{en: 1'b0, rd: '0, data: '0, gid: 3'd0};
    endtask

    // One clock: check grant, queue the expected write, pop and compare after the edge.
    task automatic cyc(input logic [NREQ-1:0] exp_rdy);
        exp_t e;
        exp_t got;
        int   g;
        @(negedge clk);
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        g = -1;
        for (int i = 0; i < NREQ; i++) if (exp_rdy[i]) g = i;
        if (g >= 0) begin
            hold.rd   = tb_rd[g];
            hold.data = tb_data[g];
            hold.gid  = 3'(g);
            e         = hold;
            e.en      = (tb_rd[g] != '0);
        end else begin
            e    = hold;
            e.en = 1'b0;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            got = sb.pop_front();
            chk("rd_wr_en", 32'(rd_wr_en), 32'(got.en));
            chk("rd",       32'(rd),       32'(got.rd));
            chk("wr_data",  32'(wr_data),  32'(got.data));
            chk("grant_id", 32'(grant_id), 32'(got.gid));
        end
    endtask

    // Short asynchronous reset pulse away from the clock edge.
    task automatic rst_pulse();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        clear_hold();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        clear_hold();
        for (int i = 0; i < NREQ; i++) begin
            tb_rd[i]   = '0;
            tb_data[i] = '0;
        end
        req_rd    = '0;
        req_data  = '0;
        rst_n     = 1'b0;
        arb_en    = 1'b1;
        req_valid = 4'b1111;

        // Reset with every requester valid: nothing granted, outputs cleared.
        #7;
        chk("rst_ready",    32'(req_ready), 32'h0);
        chk("rst_wr_en",    32'(rd_wr_en),  32'h0);
        chk("rst_rd",       32'(rd),        32'h0);
        chk("rst_wr_data",  32'(wr_data),   32'h0);
        chk("rst_grant_id", 32'(grant_id),  32'h0);
        req_valid = '0;
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single request from requester 1, then idle.
        set_req(1, 5'd5, 16'hA5A5);
        req_valid = 4'b0010;
        cyc(4'b0010);
        req_valid = 4'b0000;
        cyc(4'b0000);

        // All four valid from ptr=0: strict rotation, write every cycle.
        rst_pulse();
        set_req(0, 5'd1, 16'h1001);
        set_req(1, 5'd2, 16'h2002);
        set_req(2, 5'd3, 16'h3003);
        set_req(3, 5'd4, 16'h4004);
        req_valid = 4'b1111;
        for (int r = 0; r < 8; r++) cyc(NREQ'(1) << (r % NREQ));
        req_valid = 4'b0000;
        cyc(4'b0000);

        // r0 write: accepted, pointer advances, no write enable.
        set_req(2, 5'd0, 16'hFFFF);
        req_valid = 4'b0100;
        cyc(4'b0100);
        req_valid = 4'b0000;
        cyc(4'b0000);

        // Pointer sits at 3: grant 3 to bring it back to 0.
        req_valid = 4'b1000;
        cyc(4'b1000);

        // Frozen arbitration, then resume from the held pointer.
        arb_en    = 1'b0;
        req_valid = 4'b1001;
        cyc(4'b0000);
        cyc(4'b0000);
        cyc(4'b0000);
        arb_en = 1'b1;
        cyc(4'b0001);
        req_valid = 4'b1000;
        cyc(4'b1000);
        req_valid = 4'b0000;
        cyc(4'b0000);

        // Same-address requests are serialised in grant order.
        set_req(0, 5'd7, 16'h1111);
        set_req(1, 5'd7, 16'h2222);
        req_valid = 4'b0011;
        cyc(4'b0001);
        req_valid = 4'b0010;
        cyc(4'b0010);
        req_valid = 4'b0000;
        cyc(4'b0000);

        // Reset mid-write: write dropped at once, pointer restarts at 0.
        set_req(2, 5'd9, 16'h9999);
        req_valid = 4'b0100;
        cyc(4'b0100);
        req_valid = 4'b1111;
        rst_n     = 1'b0;
        #1;
        chk("midrst_wr_en", 32'(rd_wr_en),  32'h0);
        chk("midrst_ready", 32'(req_ready), 32'h0);
        chk("midrst_rd",    32'(rd),        32'h0);
`ifdef REGFILE_WR_ARB_STATS_EN
        chk("midrst_conflict", 32'(conflict_cnt), 32'h0);
`endif
        #1;
        rst_n = 1'b1;
        clear_hold();
        cyc(4'b0001);
        req_valid = 4'b1110;
        cyc(4'b0010);
        req_valid = 4'b1100;
        cyc(4'b0100);
        req_valid = 4'b1000;
        cyc(4'b1000);
        req_valid = 4'b0000;
        cyc(4'b0000);
`ifdef REGFILE_WR_ARB_STATS_EN
        chk("conflict_cnt", 32'(conflict_cnt), 32'd3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
